// File: rtl/shift_sequencer.sv
// Sequences the shifter through one operation: load operand, shift, write back.
// Moore decode from the state register; shift_n and err are registered.
module shift_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [4:0] shamt,
    output logic       busy,
    output logic [2:0] shift_func,
    output logic [4:0] shift_n,
    output logic       res_we,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [2:0] FUNC_HOLD = 3'b000;
    localparam logic [2:0] FUNC_LOAD = 3'b001;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] op_l;
    logic [4:0] shamt_l;
    logic       op_legal;
    logic       accept;
    logic       reject;

    // Legal shift functions are the contiguous codes sll..rol.
    assign op_legal = (op >= 3'b010) && (op <= 3'b110);
    assign accept   = (state == IDLE) && start && op_legal;
    assign reject   = (state == IDLE) && start && !op_legal;

    // shamt_l is itself a register, so it doubles as the registered shift_n.
    assign shift_n = shamt_l;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_l    <= 3'b000;
            shamt_l <= 5'd0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= reject;
            if (accept) begin
                op_l    <= op;
                shamt_l <= shamt;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        shift_func = FUNC_HOLD;
        res_we     = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                shift_func = FUNC_LOAD;
                state_nxt  = (shamt_l != 5'd0) ? SHIFT : WRITE;
            end
            SHIFT: begin
                shift_func = op_l;
                state_nxt  = WRITE;
            end
            WRITE: begin
                res_we    = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer: transaction-level timing model with a done scoreboard
// and a per-cycle expectation table, checked by an independent monitor.
module tb_shift_sequencer;

    localparam int NE = 1600;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [4:0] shamt;
    logic       busy;
    logic [2:0] shift_func;
    logic [4:0] shift_n;
    logic       res_we;
    logic       done;
    logic       err;

    shift_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .shamt     (shamt),
        .busy      (busy),
        .shift_func(shift_func),
        .shift_n   (shift_n),
        .res_we    (res_we),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         we_edge;
        logic [2:0] op;
        logic [4:0] sh;
    } txn_t;

    txn_t       sb[$];
    logic [2:0] e_func [NE+8];
    bit         e_busy [NE+8];
    bit         e_done [NE+8];
    bit         e_err  [NE+8];
    logic [4:0] e_shn  [NE+8];

    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         n      = 0;
    int         free_at = 0;
    logic [4:0] m_shn  = 5'd0;

    task automatic chk(input string nm, input int m, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, m, act, exp);
        end
    endtask

    // Drive one edge's inputs and record what that edge must produce.
    task automatic step(input bit r, input bit s, input logic [2:0] o, input logic [4:0] sh);
        bit legal;
        n++;
        reset = r;
        start = s;
        op    = o;
        shamt = sh;
        legal = (o >= 3'd2) && (o <= 3'd6);
        e_err[n] = 1'b0;
        if (r) begin
            if (sb.size() > 0 && sb[$].we_edge >= n) void'(sb.pop_back());
            for (int i = 0; i < 4; i++) begin
                e_func[n+i] = 3'b000;
                e_busy[n+i] = 1'b0;
                e_done[n+i] = 1'b0;
            end
            m_shn   = 5'd0;
            free_at = n + 1;
        end else if (s && n >= free_at) begin
            if (!legal) begin
                e_err[n] = 1'b1;
            end else begin
                txn_t t;
                int   w;
                m_shn = sh;
                w = (sh == 5'd0) ? n + 1 : n + 2;
                e_func[n] = 3'b001;
                e_busy[n] = 1'b1;
                if (sh != 5'd0) begin
                    e_func[n+1] = o;
                    e_busy[n+1] = 1'b1;
                end
                e_busy[w] = 1'b1;
                e_done[w] = 1'b1;
                t.we_edge = w;
                t.op      = o;
                t.sh      = sh;
                sb.push_back(t);
                free_at = w + 2;
            end
        end
        e_shn[n] = m_shn;
        @(negedge clk);
    endtask

    // Stimulus: directed scenarios first, then random traffic, then drain.
    initial begin
        for (int i = 0; i < NE + 8; i++) begin
            e_func[i] = 3'b000;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
            e_err[i]  = 1'b0;
            e_shn[i]  = 5'd0;
        end
        step(1, 0, 3'd0, 5'd0);
        step(1, 1, 3'd2, 5'd7);
        step(0, 0, 3'd0, 5'd0);
        step(0, 1, 3'd2, 5'd5);
        repeat (4) step(0, 0, 3'd0, 5'd0);
        step(0, 1, 3'd4, 5'd0);
        repeat (3) step(0, 0, 3'd0, 5'd0);
        step(0, 1, 3'd7, 5'd9);
        repeat (2) step(0, 0, 3'd0, 5'd0);
        step(0, 1, 3'd3, 5'd31);
        repeat (4) step(0, 1, 3'd5, 5'd2);
        repeat (5) step(0, 0, 3'd0, 5'd0);
        step(0, 1, 3'd6, 5'd3);
        step(0, 0, 3'd0, 5'd0);
        step(1, 1, 3'd2, 5'd4);
        repeat (3) step(0, 0, 3'd0, 5'd0);
        step(0, 1, 3'd5, 5'd1);
        repeat (3) step(0, 0, 3'd0, 5'd0);
        step(0, 1, 3'd6, 5'd31);
        repeat (5) step(0, 0, 3'd0, 5'd0);
        step(0, 1, 3'd0, 5'd1);
        step(0, 1, 3'd1, 5'd1);
        step(0, 0, 3'd0, 5'd0);
        while (n < NE - 8) begin
            int         k;
            logic [4:0] sh;
            k = $urandom_range(0, 3);
            sh = (k == 0) ? 5'd0 : (k == 1) ? 5'd31 : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1),
                 3'($urandom_range(0, 7)), sh);
        end
        while (n < NE) step(0, 0, 3'd0, 5'd0);
    end

    // Monitor: sample one ns after each rising edge and compare against the model.
    initial begin
        for (int m = 1; m <= NE; m++) begin
            @(posedge clk);
            #1;
            chk("busy", m, 8'(busy), 8'(e_busy[m]));
            chk("shift_func", m, 8'(shift_func), 8'(e_func[m]));
            chk("shift_n", m, 8'(shift_n), 8'(e_shn[m]));
            chk("res_we", m, 8'(res_we), 8'(e_done[m]));
            chk("done", m, 8'(done), 8'(e_done[m]));
            chk("err", m, 8'(err), 8'(e_err[m]));
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", m, 8'd1, 8'd0);
                end else begin
                    txn_t t;
                    t = sb.pop_front();
                    chk("done_edge", m, 8'(m - t.we_edge), 8'd0);
                    chk("done_shift_n", m, 8'(shift_n), 8'(t.sh));
                end
            end
        end
        chk("sb_drained", NE, 8'(sb.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
